// File: rtl/mul32_f_if.sv
// Start/busy handshake bus for the sequential fraction multiplier.
// The FPU sequencer holds the master side and the multiplier holds the slave side.
interface mul32_f_if #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned RES_WIDTH = 32
);
  logic                 start;
  logic                 busy;
  logic                 done;
  logic [WIDTH-1:0]     multiplicand;
  logic [WIDTH-1:0]     multiplier;
  logic [RES_WIDTH-1:0] res;

  modport master (
    output start,
    output multiplicand,
    output multiplier,
    input  busy,
    input  done,
    input  res
  );

  modport slave (
    input  start,
    input  multiplicand,
    input  multiplier,
    output busy,
    output done,
    output res
  );
endinterface

// File: rtl/mul32_f_top.sv
// Radix-2 shift-and-add multiplier for unsigned Q0.WIDTH fractions.
// The upper half of the product is rounded half-up to RES_WIDTH bits.
module mul32_f_top #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned RES_WIDTH   = 32,
  parameter int unsigned WIDTH_LOG_2 = 5
) (
  input  logic       clk,
  input  logic       rst,
  mul32_f_if.slave   bus
);

  localparam int unsigned ACC_W = 2 * WIDTH;
  localparam logic [WIDTH_LOG_2-1:0] CNT_LAST = WIDTH_LOG_2'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_ROUND = 2'd2
  } state_e;

  state_e                 state_q,  state_d;
  logic [WIDTH-1:0]       mcand_q,  mcand_d;
  logic [WIDTH-1:0]       mplier_q, mplier_d;
  logic [ACC_W-1:0]       acc_q,    acc_d;
  logic [WIDTH_LOG_2-1:0] cnt_q,    cnt_d;
  logic                   busy_q,   busy_d;
  logic                   done_q,   done_d;
  logic [RES_WIDTH-1:0]   res_q,    res_d;

  logic [WIDTH-1:0]       addend_c;
  logic [WIDTH:0]         sum_c;

  // State register; reset discards any partial product immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      res_q    <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      res_q    <= res_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    res_d    = res_q;

    // Partial-product add into the upper half; the carry is kept as bit WIDTH.
    addend_c = mplier_q[0] ? mcand_q : '0;
    sum_c    = {1'b0, acc_q[ACC_W-1:WIDTH]} + {1'b0, addend_c};

    unique case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        if (bus.start) begin
          mcand_d  = bus.multiplicand;
          mplier_d = bus.multiplier;
          acc_d    = '0;
          cnt_d    = '0;
          busy_d   = 1'b1;
          state_d  = S_RUN;
        end
      end

      S_RUN: begin
        // Shift {carry, acc} right by one; the carry lands in the accumulator MSB.
        acc_d    = {sum_c, acc_q[WIDTH-1:1]};
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + WIDTH_LOG_2'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = S_ROUND;
        end
      end

      S_ROUND: begin
        // Largest product has round bit 0 when the upper half is all ones, so no overflow.
        res_d   = RES_WIDTH'(acc_q[ACC_W-1:WIDTH] + WIDTH'(acc_q[WIDTH-1]));
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.res  = res_q;

endmodule

// File: tb/tb_mul32_f_top.sv
// Self-checking bench for mul32_f_top: directed vector table, handshake corner
// sequences and randomized operands against a plain-arithmetic rounding model.
module tb_mul32_f_top;

  localparam int unsigned W = 32;
  localparam int unsigned LAT = W + 1;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  mul32_f_if #(.WIDTH(W), .RES_WIDTH(W)) bus ();

  mul32_f_top #(.WIDTH(W), .RES_WIDTH(W), .WIDTH_LOG_2(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_res;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference: full 64-bit product plus half an LSB of the result, keep the top 32 bits.
  function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    p = (64'(a) * 64'(b)) + 64'h0000_0000_8000_0000;
    return p[63:32];
  endfunction

  // Drive a request at a negedge; returns at the negedge after the accepting edge.
  task automatic issue(input logic [31:0] a, input logic [31:0] b);
    bus.start        = 1'b1;
    bus.multiplicand = a;
    bus.multiplier   = b;
    @(posedge clk);
    @(negedge clk);
    check("accept_busy", 64'(bus.busy), 64'(1));
    check("accept_no_done", 64'(bus.done), 64'(0));
    bus.start = 1'b0;
  endtask

  // Waits for done with a cycle budget; optional noise on the inputs while busy.
  task automatic wait_done(input bit noisy, output int lat, output int bcnt);
    lat  = 0;
    bcnt = 1;
    while (lat < 100) begin
      if (noisy) begin
        bus.start        = 1'($urandom);
        bus.multiplicand = $urandom;
        bus.multiplier   = $urandom;
      end
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (bus.busy && bus.done) check("busy_done_excl", 64'(1), 64'(0));
      if (bus.busy) bcnt++;
      if (bus.done) begin
        bus.start = 1'b0;
        break;
      end
    end
    if (lat >= 100) check("done_timeout", 64'(lat), 64'(LAT));
  endtask

  task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res, input bit noisy);
    int lat, bcnt;
    issue(a, b);
    wait_done(noisy, lat, bcnt);
    check({name, "_latency"}, 64'(lat), 64'(LAT));
    check({name, "_busy_cycles"}, 64'(bcnt), 64'(LAT));
    check({name, "_res"}, 64'(bus.res), 64'(exp_res));
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    vec_t vecs[6];
    int lat, bcnt;
    logic [31:0] ra, rb;

    vecs[0] = '{32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
    vecs[1] = '{32'h0000_0001, 32'h8000_0000, 32'h0000_0001};
    vecs[2] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    vecs[3] = '{32'h8000_0001, 32'h8000_0001, 32'h4000_0001};
    vecs[4] = '{32'hC000_0000, 32'h4000_0000, 32'h3000_0000};
    vecs[5] = '{32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0000};

    bus.start        = 1'b0;
    bus.multiplicand = '0;
    bus.multiplier   = '0;

    // Reset then idle.
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("reset_state", 64'({bus.busy, bus.done, bus.res}), 64'(0));
    end
    rst = 1'b1;
    repeat (40) begin
      @(negedge clk);
      check("idle_state", 64'({bus.busy, bus.done, bus.res}), 64'(0));
    end

    // Directed vector table.
    foreach (vecs[i]) begin
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].exp_res, 1'b0);
      repeat (2) @(negedge clk);
    end

    // Second start at cycle 10 is ignored; a start in the done cycle is accepted.
    issue(32'h8000_0000, 32'h8000_0000);
    repeat (9) begin @(posedge clk); @(negedge clk); end
    bus.start        = 1'b1;
    bus.multiplicand = 32'h1234_5678;
    bus.multiplier   = 32'h1234_5678;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(1'b0, lat, bcnt);
    check("ignore_latency", 64'(lat), 64'(LAT - 10));
    check("ignore_res", 64'(bus.res), 64'(32'h4000_0000));
    run_op("b2b", 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0);
    repeat (40) begin
      @(negedge clk);
      check("b2b_no_extra_done", 64'(bus.done), 64'(0));
    end

    // Reset mid-operation, between clock edges.
    run_op("pre_reset", 32'h8000_0001, 32'h8000_0001, 32'h4000_0001, 1'b0);
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    repeat (14) begin @(posedge clk); @(negedge clk); end
    #2 rst = 1'b0;
    #1 check("midop_reset", 64'({bus.busy, bus.done, bus.res}), 64'(0));
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (40) begin
      @(negedge clk);
      check("after_reset_idle", 64'({bus.busy, bus.done}), 64'(0));
    end
    run_op("post_reset", 32'hC000_0000, 32'h4000_0000, 32'h3000_0000, 1'b0);

    // Reset landing in the done cycle clears the pulse and the result.
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(1'b0, lat, bcnt);
    check("done_cycle_res", 64'(bus.res), 64'(32'hFFFF_FFFE));
    #2 rst = 1'b0;
    #1 check("done_cycle_reset", 64'({bus.busy, bus.done, bus.res}), 64'(0));
    @(negedge clk);
    rst = 1'b1;

    // Random regression with random gaps, including zero-gap back-to-back.
    for (int n = 0; n < 1000; n++) begin
      int gap;
      gap = int'($urandom_range(0, 3));
      for (int g = 0; g < gap; g++) begin
        @(posedge clk);
        @(negedge clk);
        check("gap_no_done", 64'(bus.done), 64'(0));
      end
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: ra = 32'h0000_0000;
        1: rb = 32'hFFFF_FFFF;
        2: begin ra = 32'hFFFF_FFFF; rb = 32'hFFFF_FFFF; end
        default: ;
      endcase
      run_op("rand", ra, rb, model(ra, rb), 1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
